// File: rtl/fft_pkg.sv
// Shared FFT definitions: default widths and the bit-reversal helper
// used for output unscrambling.
package fft_pkg;

    localparam int FFT_DATA_W = 16;
    localparam int FFT_LOG2N  = 4;

    // Reverses the low log2n bits of idx; callers truncate to log2n bits.
    function automatic logic [7:0] bitrev(input logic [7:0] idx,
                                          input int log2n);
        logic [7:0] rev;
        rev = {<<{idx}};
        return rev >> (8 - log2n);
    endfunction

endpackage

// File: rtl/fft_pp_bank.sv
// One N-entry bank of {real,imag} samples: synchronous write port,
// combinational read port. Contents are never reset.
module fft_pp_bank
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int LOG2N  = FFT_LOG2N
) (
    input  logic                clk,
    input  logic                we,
    input  logic [LOG2N-1:0]    waddr,
    input  logic [2*DATA_W-1:0] wdata,
    input  logic [LOG2N-1:0]    raddr,
    output logic [2*DATA_W-1:0] rdata
);

    localparam int N = 1 << LOG2N;

    logic [2*DATA_W-1:0] mem_q [N];
    logic [2*DATA_W-1:0] mem_d [N];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_reorder_buf.sv
// Ping-pong frame buffer emitting each frame either bit-reversed or in
// natural order, with first/last markers and push/stall handshakes.
module fft_reorder_buf
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int LOG2N  = FFT_LOG2N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_push,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    input  logic              in_bitrev,
    output logic              in_stall,
    output logic              out_push_F,
    output logic [DATA_W-1:0] out_real_F,
    output logic [DATA_W-1:0] out_imag_F,
    output logic              out_first_F,
    output logic              out_last_F,
    input  logic              out_stall
);

    logic             wsel_q, wsel_d;
    logic             rsel_q, rsel_d;
    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic [LOG2N-1:0] rcnt_q, rcnt_d;
    logic [1:0]       full_q, full_d;
    logic [1:0]       mode_q, mode_d;

    logic                accept;
    logic                push;
    logic [LOG2N-1:0]    rev_addr;
    logic [LOG2N-1:0]    raddr;
    logic [2*DATA_W-1:0] wdata;
    logic [2*DATA_W-1:0] rdata0, rdata1, rdata;

    // Outputs are forced idle while reset is held, before state settles.
    assign in_stall = reset & full_q[wsel_q];
    assign accept   = in_push & ~in_stall;
    assign push     = reset & full_q[rsel_q] & ~out_stall;

    assign rev_addr = LOG2N'(bitrev(8'(rcnt_q), LOG2N));
    assign raddr    = mode_q[rsel_q] ? rev_addr : rcnt_q;
    assign wdata    = {in_real, in_imag};
    assign rdata    = rsel_q ? rdata1 : rdata0;

    fft_pp_bank #(.DATA_W(DATA_W), .LOG2N(LOG2N)) u_bank0 (
        .clk   (clk),
        .we    (accept & ~wsel_q),
        .waddr (wcnt_q),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata0)
    );

    fft_pp_bank #(.DATA_W(DATA_W), .LOG2N(LOG2N)) u_bank1 (
        .clk   (clk),
        .we    (accept & wsel_q),
        .waddr (wcnt_q),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata1)
    );

    // Write fills only an empty bank and read drains only a full one,
    // so both updates to full_d always hit opposite banks.
    always_comb begin
        wsel_d = wsel_q;
        rsel_d = rsel_q;
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        full_d = full_q;
        mode_d = mode_q;
        if (accept) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == '0) begin
                mode_d[wsel_q] = in_bitrev;
            end
            if (wcnt_q == '1) begin
                full_d[wsel_q] = 1'b1;
                wsel_d         = ~wsel_q;
            end
        end
        if (push) begin
            rcnt_d = rcnt_q + 1'b1;
            if (rcnt_q == '1) begin
                full_d[rsel_q] = 1'b0;
                rsel_d         = ~rsel_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
            wcnt_q <= '0;
            rcnt_q <= '0;
            full_q <= '0;
            mode_q <= '0;
        end else begin
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
            full_q <= full_d;
            mode_q <= mode_d;
        end
    end

    always_comb begin
        out_push_F  = push;
        out_real_F  = '0;
        out_imag_F  = '0;
        out_first_F = 1'b0;
        out_last_F  = 1'b0;
        if (push) begin
            out_real_F  = rdata[2*DATA_W-1:DATA_W];
            out_imag_F  = rdata[DATA_W-1:0];
            out_first_F = (rcnt_q == '0);
            out_last_F  = (rcnt_q == '1);
        end
    end

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Directed bench for fft_reorder_buf: default instance (N=16, 16-bit)
// plus a LOG2N=3 / DATA_W=24 instance.
module tb_fft_reorder_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_push, in_bitrev, out_stall;
    logic [15:0] in_real, in_imag;
    logic        in_stall, out_push_F, out_first_F, out_last_F;
    logic [15:0] out_real_F, out_imag_F;

    logic        p6_push, p6_bitrev, p6_ostall;
    logic [23:0] p6_real, p6_imag;
    logic        p6_istall, p6_opush, p6_first, p6_last;
    logic [23:0] p6_oreal, p6_oimag;

    fft_reorder_buf u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_push     (in_push),
        .in_real     (in_real),
        .in_imag     (in_imag),
        .in_bitrev   (in_bitrev),
        .in_stall    (in_stall),
        .out_push_F  (out_push_F),
        .out_real_F  (out_real_F),
        .out_imag_F  (out_imag_F),
        .out_first_F (out_first_F),
        .out_last_F  (out_last_F),
        .out_stall   (out_stall)
    );

    fft_reorder_buf #(.DATA_W(24), .LOG2N(3)) u_dut6 (
        .clk         (clk),
        .reset       (reset),
        .in_push     (p6_push),
        .in_real     (p6_real),
        .in_imag     (p6_imag),
        .in_bitrev   (p6_bitrev),
        .in_stall    (p6_istall),
        .out_push_F  (p6_opush),
        .out_real_F  (p6_oreal),
        .out_imag_F  (p6_oimag),
        .out_first_F (p6_first),
        .out_last_F  (p6_last),
        .out_stall   (p6_ostall)
    );

    int tests = 0;
    int fails = 0;

    int BR4 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int BR3 [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic [15:0] q_re [$];
    logic [15:0] q_im [$];
    bit          q_fi [$];
    bit          q_la [$];
    logic [23:0] q6_re [$];
    logic [23:0] q6_im [$];
    bit          q6_fi [$];
    bit          q6_la [$];
    int          acc_cnt;
    int          stall_viol;
    bit          last_stall;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs on the falling edge, return 1ns after rise.
    task automatic step();
        @(negedge clk);
        last_stall = in_stall;
        if (in_push && !in_stall) acc_cnt++;
        if (out_push_F) begin
            q_re.push_back(out_real_F);
            q_im.push_back(out_imag_F);
            q_fi.push_back(out_first_F);
            q_la.push_back(out_last_F);
            if (out_stall) stall_viol++;
        end
        if (p6_opush) begin
            q6_re.push_back(p6_oreal);
            q6_im.push_back(p6_oimag);
            q6_fi.push_back(p6_first);
            q6_la.push_back(p6_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        q_re.delete();
        q_im.delete();
        q_fi.delete();
        q_la.delete();
        acc_cnt    = 0;
        stall_viol = 0;
    endtask

    task automatic verify(input string tag, input int n, input bit br,
                          input int base);
        int idx;
        int v;
        chk({tag, "_cnt"}, q_re.size(), n);
        for (int p = 0; p < n && p < q_re.size(); p++) begin
            idx = br ? BR4[p % 16] : p % 16;
            v   = base + (p / 16) * 16 + idx;
            chk(tag, {q_re[p], q_im[p]}, {16'(v), 16'(-v)});
            chk({tag, "_mk"}, {30'd0, q_fi[p], q_la[p]},
                {30'd0, (p % 16 == 0), (p % 16 == 15)});
        end
    endtask

    task automatic push_one(input int v, input bit br);
        in_push   = 1'b1;
        in_real   = 16'(v);
        in_imag   = 16'(-v);
        in_bitrev = br;
        step();
    endtask

    initial begin
        int first_stall;
        int cyc;
        bit s15, s16;

        reset     = 1'b0;
        in_push   = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        in_bitrev = 1'b0;
        out_stall = 1'b0;
        p6_push   = 1'b0;
        p6_real   = '0;
        p6_imag   = '0;
        p6_bitrev = 1'b0;
        p6_ostall = 1'b0;
        clear();
        step();
        step();
        chk("rst_outs", {26'd0, in_stall, out_push_F, out_first_F,
            out_last_F, p6_opush, p6_istall}, 32'd0);
        chk("rst_data", {out_real_F, out_imag_F}, 32'd0);
        reset = 1'b1;
        step();
        chk("rst_idle", {30'd0, in_stall, out_push_F}, 32'd0);

        // 1: bit-reversed frame, latency of one cycle after the 16th accept
        clear();
        for (int k = 0; k < 16; k++) push_one(k, 1'b1);
        in_push = 1'b0;
        chk("t1_acc", acc_cnt, 16);
        chk("t1_early", q_re.size(), 0);
        step();
        chk("t1_lat", q_re.size(), 1);
        repeat (17) step();
        verify("t1", 16, 1'b1, 0);

        // 2: natural frame; bitrev raised after the first sample is ignored
        clear();
        for (int k = 0; k < 16; k++) push_one(k, k != 0);
        in_push = 1'b0;
        repeat (18) step();
        verify("t2", 16, 1'b0, 0);

        // 3: back-pressure fills both banks
        clear();
        out_stall   = 1'b1;
        first_stall = -1;
        for (int i = 0; i < 40; i++) begin
            push_one(acc_cnt, 1'b0);
            if (last_stall && first_stall < 0) first_stall = i;
        end
        in_push = 1'b0;
        chk("t3_acc", acc_cnt, 32);
        chk("t3_stall_at", first_stall, 32);
        chk("t3_noout", q_re.size(), 0);
        out_stall = 1'b0;
        s15 = 1'b0;
        s16 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 15) s15 = last_stall;
            if (i == 16) s16 = last_stall;
        end
        chk("t3_stall15", {31'd0, s15}, 32'd1);
        chk("t3_stall16", {31'd0, s16}, 32'd0);
        verify("t3", 32, 1'b0, 0);

        // 4: continuous push, consumer stalls one cycle in three
        clear();
        cyc = 0;
        while (acc_cnt < 64 && cyc < 400) begin
            out_stall = (cyc % 3 == 2);
            push_one(acc_cnt, 1'b0);
            cyc++;
        end
        in_push = 1'b0;
        while (q_re.size() < 64 && cyc < 800) begin
            out_stall = (cyc % 3 == 2);
            step();
            cyc++;
        end
        out_stall = 1'b0;
        chk("t4_acc", acc_cnt, 64);
        chk("t4_viol", stall_viol, 0);
        verify("t4", 64, 1'b0, 0);

        // 5: reset with one frame buffered and seven samples in flight
        clear();
        out_stall = 1'b1;
        for (int k = 0; k < 23; k++) push_one(100 + k, 1'b0);
        in_push = 1'b0;
        reset   = 1'b0;
        step();
        chk("t5_rst", {26'd0, in_stall, out_push_F, out_first_F,
            out_last_F, 2'd0}, 32'd0);
        chk("t5_rdat", {out_real_F, out_imag_F}, 32'd0);
        reset     = 1'b1;
        out_stall = 1'b0;
        step();
        chk("t5_after", {30'd0, in_stall, out_push_F}, 32'd0);
        clear();
        for (int k = 0; k < 16; k++) push_one(200 + k, 1'b0);
        in_push = 1'b0;
        repeat (18) step();
        verify("t5", 16, 1'b0, 200);

        // 6: LOG2N=3, DATA_W=24, most-negative value at index 1
        for (int k = 0; k < 8; k++) begin
            p6_push   = 1'b1;
            p6_real   = (k == 1) ? 24'h800000 : 24'(k);
            p6_imag   = 24'(k);
            p6_bitrev = 1'b1;
            step();
        end
        p6_push = 1'b0;
        repeat (10) step();
        chk("t6_cnt", q6_re.size(), 8);
        for (int p = 0; p < 8 && p < q6_re.size(); p++) begin
            chk("t6_im", {8'd0, q6_im[p]}, 32'(BR3[p]));
            chk("t6_mk", {30'd0, q6_fi[p], q6_la[p]},
                {30'd0, (p == 0), (p == 7)});
        end
        if (q6_re.size() > 4) begin
            chk("t6_neg", {8'd0, q6_re[4]}, 32'h0080_0000);
            chk("t6_re2", {8'd0, q6_re[2]}, 32'd2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
